// File: rtl/db_ram_arb.sv
// Two-requester round-robin arbiter for one port of the deblocking 16x128 line buffer,
// with read-return strobes and a per-entry written-since-clear scoreboard.
module db_ram_arb #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   r0_req_i,
    input  logic                   r0_we_i,
    input  logic [ADDR_W-1:0]      r0_addr_i,
    input  logic [DATA_W-1:0]      r0_data_i,
    output logic                   r0_ack_o,
    output logic                   r0_rvld_o,
    output logic [DATA_W-1:0]      r0_data_o,
    input  logic                   r1_req_i,
    input  logic                   r1_we_i,
    input  logic [ADDR_W-1:0]      r1_addr_i,
    input  logic [DATA_W-1:0]      r1_data_i,
    output logic                   r1_ack_o,
    output logic                   r1_rvld_o,
    output logic [DATA_W-1:0]      r1_data_o,
    output logic                   ram_cen_o,
    output logic                   ram_oen_o,
    output logic                   ram_wen_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [DATA_W-1:0]      ram_data_o,
    input  logic [DATA_W-1:0]      ram_data_i,
    output logic [(1<<ADDR_W)-1:0] vld_o
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic              last_gnt_q, last_gnt_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic              rvld_q, rvld_d;
    logic              rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;

    logic              e0, e1, gnt0, gnt1, gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        e0 = r0_req_i;
        // Requester 1 reads wait until the entry has been written since the last clear.
        e1 = r1_req_i & (r1_we_i | vld_q[r1_addr_i]);
        gnt0 = ~rst & e0 & (~e1 | last_gnt_q);
        gnt1 = ~rst & e1 & (~e0 | ~last_gnt_q);
        gnt  = gnt0 | gnt1;

        sel_we   = gnt1 ? r1_we_i   : r0_we_i;
        sel_addr = gnt1 ? r1_addr_i : r0_addr_i;
        sel_data = gnt1 ? r1_data_i : r0_data_i;

        last_gnt_d = gnt ? gnt1 : last_gnt_q;
        ram_addr_d = gnt ? sel_addr : ram_addr_q;
        ram_data_d = gnt ? sel_data : ram_data_q;
        rvld_d     = gnt & ~sel_we;
        rd_sel_d   = gnt ? gnt1 : rd_sel_q;

        // Clear first, then set, so a write granted alongside clear survives.
        vld_d = clear_i ? '0 : vld_q;
        if (gnt && sel_we) begin
            vld_d[sel_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            vld_q      <= '0;
            rvld_q     <= 1'b0;
            rd_sel_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            vld_q      <= vld_d;
            rvld_q     <= rvld_d;
            rd_sel_q   <= rd_sel_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign r0_ack_o   = gnt0;
    assign r1_ack_o   = gnt1;
    assign r0_rvld_o  = rvld_q & ~rd_sel_q;
    assign r1_rvld_o  = rvld_q & rd_sel_q;
    assign r0_data_o  = ram_data_i;
    assign r1_data_o  = ram_data_i;
    assign ram_cen_o  = ~gnt;
    assign ram_oen_o  = 1'b0;
    assign ram_wen_o  = ~(gnt & sel_we);
    assign ram_addr_o = ram_addr_d;
    assign ram_data_o = ram_data_d;
    assign vld_o      = vld_q;
endmodule

// File: tb/tb_db_ram_arb.sv
// Directed bench for db_ram_arb with a behavioural 16x128 registered-output RAM on the port.
module tb_db_ram_arb;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear_i;
    logic              r0_req_i, r0_we_i, r1_req_i, r1_we_i;
    logic [ADDR_W-1:0] r0_addr_i, r1_addr_i;
    logic [DATA_W-1:0] r0_data_i, r1_data_i;
    logic              r0_ack_o, r0_rvld_o, r1_ack_o, r1_rvld_o;
    logic [DATA_W-1:0] r0_data_o, r1_data_o;
    logic              ram_cen_o, ram_oen_o, ram_wen_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_data_i;
    logic [15:0]       vld_o;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem [16];

    always #5 clk = ~clk;

    // RAM model: registered read data, valid the cycle after the access.
    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) mem[ram_addr_o] <= ram_data_o;
            else            ram_data_i      <= mem[ram_addr_o];
        end
    end

    db_ram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .r0_req_i(r0_req_i), .r0_we_i(r0_we_i), .r0_addr_i(r0_addr_i), .r0_data_i(r0_data_i),
        .r0_ack_o(r0_ack_o), .r0_rvld_o(r0_rvld_o), .r0_data_o(r0_data_o),
        .r1_req_i(r1_req_i), .r1_we_i(r1_we_i), .r1_addr_i(r1_addr_i), .r1_data_i(r1_data_i),
        .r1_ack_o(r1_ack_o), .r1_rvld_o(r1_rvld_o), .r1_data_o(r1_data_o),
        .ram_cen_o(ram_cen_o), .ram_oen_o(ram_oen_o), .ram_wen_o(ram_wen_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .vld_o(vld_o)
    );

    task automatic idle_inputs();
        clear_i  = 1'b0;
        r0_req_i = 1'b0; r0_we_i = 1'b0; r0_addr_i = '0; r0_data_i = '0;
        r1_req_i = 1'b0; r1_we_i = 1'b0; r1_addr_i = '0; r1_data_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        r0_req_i = 1'b1; r0_we_i = 1'b1;
        r1_req_i = 1'b1; r1_we_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({r0_ack_o, r1_ack_o} !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", {r0_ack_o, r1_ack_o}); end
        total++; if ({ram_cen_o, ram_wen_o, ram_oen_o} !== 3'b110) begin bad++; $display("FAIL reset_ram_ctl got=%b exp=110", {ram_cen_o, ram_wen_o, ram_oen_o}); end
        total++; if (vld_o !== 16'h0000) begin bad++; $display("FAIL reset_vld got=%h exp=0000", vld_o); end
        total++; if ({r0_rvld_o, r1_rvld_o} !== 2'b00) begin bad++; $display("FAIL reset_rvld got=%b exp=00", {r0_rvld_o, r1_rvld_o}); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_tie();
        @(negedge clk);
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'd3; r0_data_i = {16{8'hA5}};
        r1_req_i = 1'b1; r1_we_i = 1'b1; r1_addr_i = 4'd5; r1_data_i = {16{8'h5A}};
        #1;
        total++; if ({r0_ack_o, r1_ack_o} !== 2'b10) begin bad++; $display("FAIL tie_first_ack got=%b exp=10", {r0_ack_o, r1_ack_o}); end
        total++; if ({ram_cen_o, ram_wen_o, ram_addr_o} !== {2'b00, 4'd3}) begin bad++; $display("FAIL tie_first_ram got=%b/%b/%0d exp=0/0/3", ram_cen_o, ram_wen_o, ram_addr_o); end
        @(negedge clk);
        r0_req_i = 1'b0;
        #1;
        total++; if ({r0_ack_o, r1_ack_o} !== 2'b01) begin bad++; $display("FAIL tie_second_ack got=%b exp=01", {r0_ack_o, r1_ack_o}); end
        total++; if ({ram_cen_o, ram_wen_o, ram_addr_o} !== {2'b00, 4'd5}) begin bad++; $display("FAIL tie_second_ram got=%b/%b/%0d exp=0/0/5", ram_cen_o, ram_wen_o, ram_addr_o); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (vld_o !== 16'h0028) begin bad++; $display("FAIL tie_vld got=%h exp=0028", vld_o); end
        total++; if ({ram_cen_o, ram_wen_o, ram_addr_o, ram_data_o} !== {2'b11, 4'd5, {16{8'h5A}}}) begin bad++; $display("FAIL idle_hold got=%b/%b/%0d/%h", ram_cen_o, ram_wen_o, ram_addr_o, ram_data_o); end
        total++; if (mem[5] !== {16{8'h5A}}) begin bad++; $display("FAIL tie_mem5 got=%h exp=%h", mem[5], {16{8'h5A}}); end
    endtask

    task automatic test_round_robin();
        int n0 = 0;
        int n1 = 0;
        @(negedge clk);
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'd0; r0_data_i = {8{16'h0F0F}};
        r1_req_i = 1'b1; r1_we_i = 1'b1; r1_addr_i = 4'd1; r1_data_i = {8{16'hF0F0}};
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if ({r0_ack_o, r1_ack_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rr_cycle%0d got=%b exp=%b", i, {r0_ack_o, r1_ack_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            n0 += int'(r0_ack_o);
            n1 += int'(r1_ack_o);
            @(negedge clk);
        end
        idle_inputs();
        total++; if (n0 != 4 || n1 != 4) begin bad++; $display("FAIL rr_counts got=%0d/%0d exp=4/4", n0, n1); end
        #1;
        total++; if (vld_o !== 16'h002B) begin bad++; $display("FAIL rr_vld got=%h exp=002b", vld_o); end
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'd7; r0_data_i = {8{16'h1234}};
        @(negedge clk);
        r0_we_i = 1'b0;
        #1;
        total++; if ({r0_ack_o, ram_cen_o, ram_wen_o, ram_addr_o} !== {3'b101, 4'd7}) begin bad++; $display("FAIL rd_grant got=%b/%b/%b/%0d exp=1/0/1/7", r0_ack_o, ram_cen_o, ram_wen_o, ram_addr_o); end
        total++; if (r0_rvld_o !== 1'b0) begin bad++; $display("FAIL rd_early_rvld got=%b exp=0", r0_rvld_o); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if ({r0_rvld_o, r1_rvld_o} !== 2'b10 || r0_data_o !== {8{16'h1234}}) begin bad++; $display("FAIL rd_return rvld=%b data=%h exp=10/%h", {r0_rvld_o, r1_rvld_o}, r0_data_o, {8{16'h1234}}); end
        @(negedge clk);
        #1;
        total++; if (r0_rvld_o !== 1'b0) begin bad++; $display("FAIL rd_one_shot got=%b exp=0", r0_rvld_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        r0_req_i = 1'b1; r0_we_i = 1'b0; r0_addr_i = 4'd3;
        @(negedge clk);
        r0_addr_i = 4'd7;
        #1;
        total++; if (r0_ack_o !== 1'b1 || r0_rvld_o !== 1'b1 || r0_data_o !== {16{8'hA5}}) begin bad++; $display("FAIL b2b_first ack=%b rvld=%b data=%h", r0_ack_o, r0_rvld_o, r0_data_o); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (r0_rvld_o !== 1'b1 || r0_data_o !== {8{16'h1234}}) begin bad++; $display("FAIL b2b_second rvld=%b data=%h exp=1/%h", r0_rvld_o, r0_data_o, {8{16'h1234}}); end
    endtask

    task automatic test_blocked_read();
        @(negedge clk);
        r1_req_i = 1'b1; r1_we_i = 1'b0; r1_addr_i = 4'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (r1_ack_o !== 1'b0 || ram_cen_o !== 1'b1) begin bad++; $display("FAIL blk_hold%0d ack=%b cen=%b exp=0/1", i, r1_ack_o, ram_cen_o); end
            @(negedge clk);
        end
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'd9; r0_data_i = {4{32'hCAFE_0009}};
        #1;
        total++; if ({r0_ack_o, r1_ack_o} !== 2'b10) begin bad++; $display("FAIL blk_write_ack got=%b exp=10", {r0_ack_o, r1_ack_o}); end
        @(negedge clk);
        r0_req_i = 1'b0;
        #1;
        total++; if (r1_ack_o !== 1'b1 || ram_wen_o !== 1'b1 || ram_addr_o !== 4'd9) begin bad++; $display("FAIL blk_read_ack ack=%b wen=%b addr=%0d exp=1/1/9", r1_ack_o, ram_wen_o, ram_addr_o); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if ({r0_rvld_o, r1_rvld_o} !== 2'b01 || r1_data_o !== {4{32'hCAFE_0009}}) begin bad++; $display("FAIL blk_return rvld=%b data=%h exp=01/%h", {r0_rvld_o, r1_rvld_o}, r1_data_o, {4{32'hCAFE_0009}}); end
    endtask

    task automatic test_clear_vs_write();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'(a); r0_data_i = 128'(a);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (vld_o !== 16'hFFFF) begin bad++; $display("FAIL clr_full got=%h exp=ffff", vld_o); end
        @(negedge clk);
        clear_i = 1'b1;
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'd2; r0_data_i = {16{8'h22}};
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (vld_o !== 16'h0004) begin bad++; $display("FAIL clr_write_wins got=%h exp=0004", vld_o); end
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        total++; if (vld_o !== 16'h0000) begin bad++; $display("FAIL clr_plain got=%h exp=0000", vld_o); end
    endtask

    task automatic test_mid_read_reset();
        @(negedge clk);
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'd4; r0_data_i = {16{8'h44}};
        @(negedge clk);
        r0_we_i = 1'b0;
        #1;
        total++; if (r0_ack_o !== 1'b1) begin bad++; $display("FAIL mrr_read_ack got=%b exp=1", r0_ack_o); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        total++; if ({r0_rvld_o, r1_rvld_o} !== 2'b00 || vld_o !== 16'h0000 || ram_cen_o !== 1'b1) begin bad++; $display("FAIL mrr_in_reset rvld=%b vld=%h cen=%b exp=00/0000/1", {r0_rvld_o, r1_rvld_o}, vld_o, ram_cen_o); end
        r0_req_i = 1'b1; r0_we_i = 1'b1; r0_addr_i = 4'd1;
        r1_req_i = 1'b1; r1_we_i = 1'b1; r1_addr_i = 4'd6;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({r0_ack_o, r1_ack_o} !== 2'b10) begin bad++; $display("FAIL mrr_first_ack got=%b exp=10", {r0_ack_o, r1_ack_o}); end
        @(negedge clk);
        r0_req_i = 1'b0;
        #1;
        total++; if ({r0_ack_o, r1_ack_o} !== 2'b01) begin bad++; $display("FAIL mrr_second_ack got=%b exp=01", {r0_ack_o, r1_ack_o}); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (vld_o !== 16'h0042) begin bad++; $display("FAIL mrr_vld got=%h exp=0042", vld_o); end
    endtask

    initial begin
        ram_data_i = '0;
        test_reset();
        test_tie();
        test_round_robin();
        test_read_latency();
        test_back_to_back();
        test_blocked_read();
        test_clear_vs_write();
        test_mid_read_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
